// File: rtl/vram_arbiter.sv
// vram_arbiter: single-owner scheduler for the six 8 KB VRAM planes.
// One shared plane-RAM port serves CPU accesses, VDP fetches and the fill engine.
module vram_arbiter #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic [5:0]    cpu_wr_mask,
    input  logic [7:0]    cpu_rd_sel,
    output logic          cpu_ack,
    output logic [7:0]    cpu_dout,
    output logic          cpu_wait_n,
    input  logic          vdp_req,
    input  logic [AW-1:0] vdp_addr,
    output logic          vdp_ack,
    output logic [47:0]   vdp_data,
    output logic          vdp_ovf,
    input  logic          fill_start,
    input  logic [5:0]    fill_mask,
    input  logic [7:0]    fill_data,
    output logic          fill_busy,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic [5:0]    ram_we,
    input  logic [47:0]   ram_q
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_CAP} state_t;
    typedef enum logic [1:0] {O_NONE, O_VDP, O_CPU, O_FILL} owner_t;

    state_t        state, state_nx;
    owner_t        owner, grant;
    logic          vdp_pend;
    logic [AW-1:0] vdp_addr_q;
    logic [AW-1:0] vdp_addr_eff;
    logic          cpu_fl;
    logic          cpu_rd_q;
    logic          last_vdp;
    logic [AW-1:0] fill_addr;
    logic [5:0]    fill_mask_q;
    logic [7:0]    fill_data_q;
    logic          cpu_pend;
    logic          vdp_any;
    logic          slot;
    logic          vdp_win;
    logic          cpu_win;
    logic          fill_win;
    logic [7:0]    rd_byte;

    assign cpu_wait_n   = ~cpu_req | cpu_ack;
    // the ack cycle still sees cpu_req high, so it must not re-arm a grant
    assign cpu_pend     = cpu_req & ~cpu_fl & ~cpu_ack;
    assign vdp_any      = vdp_pend | vdp_req;
    assign vdp_addr_eff = vdp_req ? vdp_addr : vdp_addr_q;
    assign slot         = (state == S_IDLE) || (state == S_CAP);

    assign vdp_win  = slot & vdp_any & ~(cpu_pend & last_vdp);
    assign cpu_win  = slot & cpu_pend & ~vdp_win;
    assign fill_win = slot & fill_busy & ~vdp_any & ~cpu_pend;

    always_comb begin
        grant = O_NONE;
        unique case (1'b1)
            vdp_win:  grant = O_VDP;
            cpu_win:  grant = O_CPU;
            fill_win: grant = O_FILL;
            default:  grant = O_NONE;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (grant != O_NONE) state_nx = S_ACC;
            S_ACC:   state_nx = S_CAP;
            S_CAP:   state_nx = (grant != O_NONE) ? S_ACC : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rd_byte = 8'h00;
        unique case (cpu_rd_sel)
            8'd1:    rd_byte = ram_q[7:0];
            8'd2:    rd_byte = ram_q[15:8];
            8'd3:    rd_byte = ram_q[23:16];
            8'd4:    rd_byte = ram_q[31:24];
            8'd5:    rd_byte = ram_q[39:32];
            8'd6:    rd_byte = ram_q[47:40];
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner       <= O_NONE;
            vdp_pend    <= 1'b0;
            vdp_addr_q  <= '0;
            vdp_ovf     <= 1'b0;
            vdp_ack     <= 1'b0;
            vdp_data    <= '0;
            cpu_fl      <= 1'b0;
            cpu_rd_q    <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_dout    <= '0;
            last_vdp    <= 1'b0;
            fill_busy   <= 1'b0;
            fill_addr   <= '0;
            fill_mask_q <= '0;
            fill_data_q <= '0;
            ram_addr    <= '0;
            ram_din     <= '0;
            ram_we      <= '0;
        end else begin
            cpu_ack <= 1'b0;
            vdp_ack <= 1'b0;
            ram_we  <= '0;

            if (grant == O_VDP) vdp_pend <= 1'b0;
            else if (vdp_req)   vdp_pend <= 1'b1;
            if (vdp_req) begin
                vdp_addr_q <= vdp_addr;
                if (vdp_pend) vdp_ovf <= 1'b1;
            end

            if (fill_start && !fill_busy) begin
                fill_busy   <= 1'b1;
                fill_addr   <= '0;
                fill_mask_q <= fill_mask;
                fill_data_q <= fill_data;
            end

            if (grant != O_NONE) begin
                owner    <= grant;
                last_vdp <= (grant == O_VDP);
            end

            unique case (grant)
                O_VDP: ram_addr <= vdp_addr_eff;
                O_CPU: begin
                    ram_addr <= cpu_addr;
                    ram_din  <= cpu_din;
                    ram_we   <= cpu_we ? cpu_wr_mask : 6'd0;
                    cpu_fl   <= 1'b1;
                    cpu_rd_q <= ~cpu_we;
                end
                O_FILL: begin
                    ram_addr <= fill_addr;
                    ram_din  <= fill_data_q;
                    ram_we   <= fill_mask_q;
                end
                default: ;
            endcase

            if (state == S_ACC && owner == O_FILL) begin
                fill_addr <= fill_addr + AW'(1);
                if (&fill_addr) fill_busy <= 1'b0;
            end

            if (state == S_CAP) begin
                unique case (owner)
                    O_VDP: begin
                        vdp_data <= ram_q;
                        vdp_ack  <= 1'b1;
                    end
                    O_CPU: begin
                        cpu_ack <= 1'b1;
                        cpu_fl  <= 1'b0;
                        if (cpu_rd_q) cpu_dout <= rd_byte;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: random and directed checks of vram_arbiter against
// a transaction-level plane model with latency rules.
module tb_vram_arbiter;
    localparam int AW = 13;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic [5:0]    cpu_wr_mask = '0;
    logic [7:0]    cpu_rd_sel = '0;
    logic          cpu_ack, cpu_wait_n;
    logic [7:0]    cpu_dout;
    logic          vdp_req = 1'b0;
    logic [AW-1:0] vdp_addr = '0;
    logic          vdp_ack, vdp_ovf;
    logic [47:0]   vdp_data;
    logic          fill_start = 1'b0;
    logic [5:0]    fill_mask = '0;
    logic [7:0]    fill_data = '0;
    logic          fill_busy;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic [5:0]    ram_we;
    logic [47:0]   ram_q;

    always #5 clk = ~clk;

    vram_arbiter #(.AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_wr_mask(cpu_wr_mask), .cpu_rd_sel(cpu_rd_sel),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n),
        .vdp_req(vdp_req), .vdp_addr(vdp_addr), .vdp_ack(vdp_ack),
        .vdp_data(vdp_data), .vdp_ovf(vdp_ovf),
        .fill_start(fill_start), .fill_mask(fill_mask), .fill_data(fill_data),
        .fill_busy(fill_busy), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_q(ram_q)
    );

    logic [7:0] mem    [6][N];
    logic [7:0] shadow [6][N];

    int total = 0;
    int bad = 0;
    int wait_bad = 0;

    function automatic logic [7:0] init_val(input int p, input int a);
        return 8'(((p * 37) + (a * 13) + (a >> 5)) ^ 8'h5A);
    endfunction

    // plane RAMs: synchronous read, data one cycle after the address
    initial begin
        for (int p = 0; p < 6; p++)
            for (int a = 0; a < N; a++) mem[p][a] = init_val(p, a);
        forever begin
            @(posedge clk);
            for (int p = 0; p < 6; p++) begin
                ram_q[8*p +: 8] <= mem[p][ram_addr];
                if (ram_we[p]) mem[p][ram_addr] <= ram_din;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rd_exp(input logic [7:0] sel,
                                          input logic [AW-1:0] a);
        if (sel >= 8'd1 && sel <= 8'd6) return shadow[sel-1][a];
        return 8'h00;
    endfunction

    function automatic logic [47:0] fetch_exp(input logic [AW-1:0] a);
        logic [47:0] r;
        for (int p = 0; p < 6; p++) r[8*p +: 8] = shadow[p][a];
        return r;
    endfunction

    task automatic cpu_op(input logic we, input logic [AW-1:0] a,
                          input logic [7:0] d, input logic [5:0] m,
                          input logic [7:0] sel, output int lat,
                          output logic [7:0] q);
        cpu_we = we; cpu_addr = a; cpu_din = d;
        cpu_wr_mask = m; cpu_rd_sel = sel;
        cpu_req = 1'b1;
        lat = 0;
        q = 8'h00;
        #1 if (cpu_wait_n !== 1'b0) wait_bad++;
        while (lat < 40) begin
            tick();
            lat++;
            if (cpu_ack) break;
            if (cpu_wait_n !== 1'b0) wait_bad++;
        end
        if (cpu_ack) q = cpu_dout;
        else check("cpu_ack_timeout", cpu_ack, 1);
        cpu_req = 1'b0;
        if (we)
            for (int p = 0; p < 6; p++) if (m[p]) shadow[p][a] = d;
    endtask

    // fill monitor: writes must walk addresses upward with constant mask/data
    int            fmon_on = 0;
    int            fwrites = 0;
    int            ferr = 0;
    int            busy_cyc = 0;
    logic [AW-1:0] fexp_addr = '0;
    logic [5:0]    fexp_mask = '0;
    logic [7:0]    fexp_data = '0;

    always @(negedge clk) begin
        if (fill_busy) busy_cyc++;
        if (fmon_on != 0 && ram_we != 6'd0) begin
            if (ram_addr !== fexp_addr || ram_we !== fexp_mask ||
                ram_din !== fexp_data) ferr++;
            fexp_addr++;
            fwrites++;
        end
    end

    task automatic start_fill(input logic [5:0] m, input logic [7:0] d);
        fexp_addr = '0; fexp_mask = m; fexp_data = d;
        fwrites = 0; ferr = 0; busy_cyc = 0; fmon_on = 1;
        fill_mask = m; fill_data = d; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int p = 0; p < 6; p++)
            if (m[p]) for (int a = 0; a < N; a++) shadow[p][a] = d;
    endtask

    task automatic wait_fill(input string tag, input int exp_cyc);
        int n = 0;
        while (fill_busy && n < 20000) begin
            tick();
            n++;
        end
        check({tag, "_done"}, fill_busy, 0);
        check({tag, "_cycles"}, busy_cyc, exp_cyc);
        check({tag, "_writes"}, fwrites, N);
        check({tag, "_seq"}, ferr, 0);
        fmon_on = 0;
    endtask

    task automatic read_ends(input string tag);
        int lat;
        logic [7:0] q, e;
        for (int s = 1; s <= 6; s++) begin
            for (int k = 0; k < 2; k++) begin
                logic [AW-1:0] a;
                a = (k == 0) ? '0 : AW'(N - 1);
                e = rd_exp(8'(s), a);
                tick();
                cpu_op(1'b0, a, 8'h00, 6'h00, 8'(s), lat, q);
                check($sformatf("%s_p%0d_a%0h", tag, s, a), q, e);
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int lat, vc, cc, wl, nv, nc, rw;
        logic [7:0] q, e, cd;
        logic [47:0] vd, ev;
        logic [AW-1:0] a1, a2;

        for (int p = 0; p < 6; p++)
            for (int a = 0; a < N; a++) shadow[p][a] = init_val(p, a);

        // reset values
        repeat (3) tick();
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_vdp_ack", vdp_ack, 0);
        check("rst_vdp_data", vdp_data, 0);
        check("rst_vdp_ovf", vdp_ovf, 0);
        check("rst_fill_busy", fill_busy, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_wait_idle", cpu_wait_n, 1);
        cpu_req = 1'b1;
        #1 check("rst_wait_req", cpu_wait_n, 0);
        cpu_req = 1'b0;
        reset_n = 1'b1;
        tick();

        // write A5h to all planes, read back through every rd_sel
        tick();
        cpu_op(1'b1, 13'h0123, 8'hA5, 6'h3F, 8'd0, lat, q);
        check("a5_wr_lat", lat, 3);
        for (int s = 0; s <= 7; s++) begin
            e = rd_exp(8'(s), 13'h0123);
            tick();
            cpu_op(1'b0, 13'h0123, 8'h00, 6'h00, 8'(s), lat, q);
            check($sformatf("a5_rd_sel%0d", s), q, e);
            check($sformatf("a5_rd_lat%0d", s), lat, 3);
        end
        check("a5_expect_plane1", rd_exp(8'd1, 13'h0123), 8'hA5);

        // simultaneous CPU read and VDP fetch from idle
        tick();
        e = rd_exp(8'd3, 13'h0777);
        ev = fetch_exp(13'h1234);
        cpu_we = 1'b0; cpu_addr = 13'h0777; cpu_rd_sel = 8'd3; cpu_req = 1'b1;
        vdp_addr = 13'h1234; vdp_req = 1'b1;
        #1 check("sim_wait_k", cpu_wait_n, 0);
        vc = -1; cc = -1; wl = 0; vd = '0; cd = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            vdp_req = 1'b0;
            if (vdp_ack) begin vc = c; vd = vdp_data; end
            if (cpu_ack) begin cc = c; cd = cpu_dout; cpu_req = 1'b0; end
            else if (cpu_req && !cpu_wait_n) wl++;
        end
        check("sim_vdp_ack_cyc", vc, 3);
        check("sim_cpu_ack_cyc", cc, 5);
        check("sim_wait_low", wl, 4);
        check("sim_vdp_data", vd, ev);
        check("sim_cpu_data", cd, e);

        // random CPU and VDP traffic; VDP pulses at least 4 cycles apart
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic w;
                    logic [AW-1:0] a;
                    logic [7:0] s, d;
                    logic [5:0] m;
                    w = 1'($urandom);
                    a = w ? AW'($urandom_range(0, 255))
                          : AW'($urandom_range(0, 1) * 13'h1000 +
                                $urandom_range(0, 255));
                    s = 8'($urandom_range(0, 7));
                    d = 8'($urandom);
                    m = 6'($urandom);
                    e = rd_exp(s, a);
                    repeat ($urandom_range(1, 3)) tick();
                    cpu_op(w, a, d, m, s, lat, q);
                    if (!w) check($sformatf("mix_rd%0d", i), q, e);
                    check($sformatf("mix_lat%0d_le6", i), lat <= 6, 1);
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [AW-1:0] a;
                    int n;
                    a = AW'(13'h1000 + $urandom_range(0, 255));
                    vdp_addr = a; vdp_req = 1'b1;
                    tick();
                    vdp_req = 1'b0;
                    n = 1;
                    while (!vdp_ack && n < 30) begin tick(); n++; end
                    check($sformatf("mix_vdp_ack%0d", i), vdp_ack, 1);
                    check($sformatf("mix_vdp%0d", i), vdp_data, fetch_exp(a));
                    repeat ($urandom_range(1, 4)) tick();
                end
            end
        join
        check("mix_no_ovf", vdp_ovf, 0);
        check("wait_n_low_while_pending", wait_bad, 0);

        // VDP overrun while the CPU holds the bus
        tick();
        a1 = 13'h1100; a2 = 13'h1180;
        ev = fetch_exp(a2);
        cpu_we = 1'b1; cpu_addr = 13'h0500; cpu_din = 8'h3C;
        cpu_wr_mask = 6'h21; cpu_req = 1'b1;
        tick();
        vdp_addr = a1; vdp_req = 1'b1;
        tick();
        vdp_addr = a2; vdp_req = 1'b1;
        tick();
        vdp_req = 1'b0;
        nv = 0; nc = 0; vd = '0;
        for (int c = 0; c < 10; c++) begin
            if (vdp_ack) begin nv++; vd = vdp_data; end
            if (cpu_ack) begin nc++; cpu_req = 1'b0; end
            tick();
        end
        shadow[0][13'h0500] = 8'h3C;
        shadow[5][13'h0500] = 8'h3C;
        check("ovf_flag", vdp_ovf, 1);
        check("ovf_fetch_count", nv, 1);
        check("ovf_cpu_count", nc, 1);
        check("ovf_data_second", vd, ev);

        // fill planes 1 and 3 with 00h; a second start mid-fill is ignored
        tick();
        start_fill(6'h05, 8'h00);
        repeat (3000) tick();
        fill_mask = 6'h3F; fill_data = 8'hFF; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        wait_fill("fillA", 16384);
        read_ends("fillA");

        // CPU read around fill_addr 0100h steals exactly one slot
        tick();
        start_fill(6'h3A, 8'h96);
        repeat (512) tick();
        e = rd_exp(8'd2, 13'h0040);
        cpu_op(1'b0, 13'h0040, 8'h00, 6'h00, 8'd2, lat, q);
        check("fillB_cpu_rd", q, e);
        check("fillB_cpu_lat_le5", lat <= 5, 1);
        wait_fill("fillB", 16386);

        // reset at fill_addr 0800h aborts the fill; a restart begins at 0
        tick();
        start_fill(6'h3F, 8'h5C);
        repeat (2 * 12'h800) tick();
        fmon_on = 0;
        reset_n = 1'b0;
        tick();
        check("rstfill_busy", fill_busy, 0);
        check("rstfill_ram_we", ram_we, 0);
        check("rstfill_ovf", vdp_ovf, 0);
        reset_n = 1'b1;
        rw = 0;
        repeat (6) begin
            tick();
            if (ram_we != 6'd0) rw++;
        end
        check("rstfill_no_we", rw, 0);
        check("rstfill_idle", fill_busy, 0);
        start_fill(6'h3F, 8'h5C);
        wait_fill("fillD", 16384);
        read_ends("fillD");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
